// File: rtl/umtrx_vita_tx_deframer.sv
// umtrx_vita_tx_deframer: unpacks VITA TX packets into timed DUC sample bursts
module umtrx_vita_tx_deframer #(
    parameter int USE_TIME = 1,
    parameter int DSPNO    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [63:0] vita_time,
    input  logic [35:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        strobe,
    output logic [31:0] sample,
    output logic        run,
    output logic        err_stb,
    output logic [7:0]  err_code
);
    typedef enum logic [2:0] {HDR, SID, TSF_HI, TSF_LO, WAIT_TIME, RUN, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] word, sample_n;
    logic [63:0] tsf, tsf_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  seq, seq_n, code_n;
    logic        sof, eof, xfer, run_n, err_n;
    logic        has_tsf, has_tsf_n, eob, eob_n, armed, armed_n, first, first_n, pend, pend_n;
    logic        unused_bits;

    assign word        = in_data[31:0];
    assign sof         = in_data[32];
    assign eof         = in_data[33];
    assign unused_bits = ^in_data[35:34];
    assign in_ready    = (state == WAIT_TIME) ? 1'b0 : (state == RUN) ? strobe : 1'b1;
    assign xfer        = in_valid && in_ready;

    // Next-state and datapath decisions; pend drops run one cycle after an EOB's last sample shows
    always_comb begin
        state_n   = state;
        run_n     = run;
        sample_n  = sample;
        cnt_n     = cnt;
        tsf_n     = tsf;
        has_tsf_n = has_tsf;
        eob_n     = eob;
        seq_n     = seq;
        armed_n   = armed;
        first_n   = 1'b0;
        pend_n    = 1'b0;
        err_n     = 1'b0;
        code_n    = 4'd0;
        if (pend) begin
            run_n    = 1'b0;
            sample_n = '0;
        end
        case (state)
            HDR: if (xfer && sof) begin
                has_tsf_n = word[20];
                eob_n     = word[24];
                seq_n     = word[19:16];
                armed_n   = 1'b1;
                cnt_n     = word[15:0] - (word[20] ? 16'd4 : 16'd2);
                if (armed && word[19:16] != seq + 4'd1) begin
                    err_n  = 1'b1;
                    code_n = 4'd4;
                end
                state_n = SID;
            end
            SID: if (xfer) begin
                state_n = has_tsf ? TSF_HI : RUN;
                if (!has_tsf) run_n = 1'b1;
            end
            TSF_HI: if (xfer) begin
                tsf_n[63:32] = word;
                state_n      = TSF_LO;
            end
            TSF_LO: if (xfer) begin
                tsf_n[31:0] = word;
                if (!run && USE_TIME != 0) begin
                    state_n = WAIT_TIME;
                    first_n = 1'b1;
                end else begin
                    state_n = RUN;
                    run_n   = 1'b1;
                end
            end
            WAIT_TIME: if (first && vita_time > tsf) begin
                err_n    = 1'b1;
                code_n   = 4'd2;
                state_n  = DROP;
                run_n    = 1'b0;
                sample_n = '0;
            end else if (vita_time >= tsf) begin
                state_n = RUN;
                run_n   = 1'b1;
            end
            RUN: if (strobe && !in_valid) begin
                sample_n = '0;
                err_n    = 1'b1;
                code_n   = 4'd1;
            end else if (xfer) begin
                sample_n = word;
                cnt_n    = cnt - 16'd1;
                if (eof && cnt == 16'd1) begin
                    state_n = HDR;
                    pend_n  = eob;
                end else if (eof || cnt <= 16'd1) begin
                    err_n    = 1'b1;
                    code_n   = 4'd3;
                    state_n  = eof ? HDR : DROP;
                    run_n    = 1'b0;
                    sample_n = '0;
                end
            end
            DROP: if (xfer && eof) state_n = HDR;
            default: state_n = HDR;
        endcase
    end

    // State register; abort returns to header hunting
    always_ff @(posedge clk) begin
        if (reset || clear) state <= HDR;
        else                state <= state_n;
    end

    // Datapath, burst and error registers
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run      <= 1'b0;
            sample   <= '0;
            err_stb  <= 1'b0;
            err_code <= '0;
            cnt      <= '0;
            tsf      <= '0;
            has_tsf  <= 1'b0;
            eob      <= 1'b0;
            seq      <= '0;
            armed    <= 1'b0;
            first    <= 1'b0;
            pend     <= 1'b0;
        end else begin
            run      <= run_n;
            sample   <= sample_n;
            err_stb  <= err_n;
            err_code <= err_n ? {4'(DSPNO), code_n} : 8'd0;
            cnt      <= cnt_n;
            tsf      <= tsf_n;
            has_tsf  <= has_tsf_n;
            eob      <= eob_n;
            seq      <= seq_n;
            armed    <= armed_n;
            first    <= first_n;
            pend     <= pend_n;
        end
    end
endmodule

// File: tb/tb_umtrx_vita_tx_deframer.sv
// tb_umtrx_vita_tx_deframer: packet table plus scoreboarded samples and error codes
module tb_umtrx_vita_tx_deframer;
    typedef struct {
        logic [3:0] seq;
        bit         tsf_en;
        bit         eob;
        int         tsf_rel;
        int         len_extra;
        int         npay;
        logic [7:0] err;
        bit         play;
        bit         run_after;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, strobe, pay;
    logic [63:0] vita_time;
    logic [35:0] in_data;
    logic        in_ready, run, err_stb;
    logic [31:0] sample;
    logic [7:0]  err_code;
    int          checks = 0, errors = 0, last_wait;
    logic [63:0] last_vt, first_vt;
    logic [31:0] sb[$];
    logic [7:0]  eq[$];
    bit          xfer_prev = 1'b0;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    umtrx_vita_tx_deframer dut (
        .clk(clk), .reset(reset), .clear(clear), .vita_time(vita_time),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .strobe(strobe),
        .sample(sample), .run(run), .err_stb(err_stb), .err_code(err_code)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        vita_time = vita_time + 1;
    endtask

    function automatic logic [31:0] hdr(input logic e, input logic t, input logic [3:0] s, input logic [15:0] l);
        return {7'd0, e, 3'd0, t, s, l};
    endfunction

    task automatic send_word(input logic [31:0] d, input bit s, input bit e, input bit p);
        int t = 0;
        in_data  = {2'b00, e, s, d};
        in_valid = 1'b1;
        pay      = p;
        #1;
        while (!in_ready && t < 600) begin
            cyc();
            #1;
            t++;
        end
        last_wait = t;
        last_vt   = vita_time;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready 0 after %0d cycles, required 1", t);
        end else cyc();
        in_valid = 1'b0;
        pay      = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] s, input bit t, input bit e, input logic [63:0] ts,
                            input int len_extra, input int npay, input bit play);
        int          hw = t ? 4 : 2;
        int          rem = npay + len_extra;
        bit          drop = 1'b0, last, p;
        logic [31:0] d;
        send_word(hdr(e, t, s, 16'(hw + npay + len_extra)), 1'b1, 1'b0, 1'b0);
        send_word($urandom, 1'b0, 1'b0, 1'b0);
        if (t) begin
            send_word(ts[63:32], 1'b0, 1'b0, 1'b0);
            send_word(ts[31:0], 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < npay; i++) begin
            last = (i == npay - 1);
            p    = play && !drop;
            d    = $urandom;
            if (p) begin
                sb.push_back((last ? rem == 1 : rem > 1) ? d : 32'd0);
                if (!last && rem <= 1) drop = 1'b1;
            end
            send_word(d, 1'b0, last, p);
            if (i == 0) first_vt = last_vt;
            rem--;
        end
    endtask

    // Scoreboard: pops an expected sample one cycle after each payload transfer, and a code per err_stb
    always @(negedge clk) begin
        if (xfer_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_extra: got %0h, required none", sample);
            end else chk("sample", sample, sb.pop_front());
        end
        xfer_prev = in_valid && in_ready && strobe && pay;
        if (err_stb) begin
            if (eq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL err_extra: got code %0h, required none", err_code);
            end else chk("err_code", err_code, eq.pop_front());
        end
        if (!run) chk("idle_sample", sample, 0);
    end

    initial begin
        logic [31:0] d;
        logic [63:0] tsf;
        int          stall;
        vec_t        r;
        vecs[0] = '{4'd12, 1'b1, 1'b0,   20,  0, 3, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{4'd13, 1'b1, 1'b0, 5000,  0, 2, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{4'd14, 1'b0, 1'b1,    0,  0, 2, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{4'd15, 1'b1, 1'b1, -100,  0, 3, 8'h02, 1'b0, 1'b0};
        vecs[4] = '{4'd0,  1'b0, 1'b0,    0,  2, 4, 8'h03, 1'b1, 1'b0};
        vecs[5] = '{4'd1,  1'b0, 1'b1,    0,  0, 3, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{4'd3,  1'b1, 1'b1,   10,  0, 2, 8'h04, 1'b1, 1'b0};
        vecs[7] = '{4'd4,  1'b0, 1'b1,    0,  0, 2, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{4'd5,  1'b0, 1'b1,    0, -1, 3, 8'h03, 1'b1, 1'b0};
        vecs[9] = '{4'd6,  1'b0, 1'b1,    0,  0, 2, 8'h00, 1'b1, 1'b0};
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; strobe = 1'b0; pay = 1'b0;
        in_data = '0; vita_time = '0;
        cyc();
        cyc();
        chk("rst_run", run, 0);
        chk("rst_sample", sample, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_err_stb", err_stb, 0);
        chk("rst_err_code", err_code, 0);
        reset  = 1'b0;
        strobe = 1'b1;
        cyc();

        vita_time = 64'd900;
        send_word(hdr(1'b1, 1'b1, 4'd11, 16'd8), 1'b1, 1'b0, 1'b0);
        send_word(32'h0000_00aa, 1'b0, 1'b0, 1'b0);
        send_word(32'd0, 1'b0, 1'b0, 1'b0);
        send_word(32'd1000, 1'b0, 1'b0, 1'b0);
        chk("wait_run", run, 0);
        chk("wait_ready", in_ready, 0);
        stall = 0;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            sb.push_back(d);
            send_word(d, 1'b0, i == 3, 1'b1);
            if (i == 0) chk("start_time", last_vt, 64'd1001);
            else stall += last_wait;
        end
        chk("start_stall", stall, 0);
        chk("run_last", run, 1);
        cyc();
        chk("run_fall", run, 0);
        chk("sample_fall", sample, 0);
        cyc();

        for (int k = 0; k < 10; k++) begin
            r = vecs[k];
            if (r.err != 8'h00) eq.push_back(r.err);
            tsf = vita_time + 64'(r.tsf_rel);
            send_pkt(r.seq, r.tsf_en, r.eob, tsf, r.len_extra, r.npay, r.play);
            cyc();
            cyc();
            chk($sformatf("run_after_%0d", k), run, r.run_after);
        end

        send_pkt(4'd7, 1'b0, 1'b0, 64'd0, 0, 2, 1'b1);
        send_word(hdr(1'b1, 1'b0, 4'd8, 16'd4), 1'b1, 1'b0, 1'b0);
        send_word(32'h5, 1'b0, 1'b0, 1'b0);
        repeat (3) eq.push_back(8'h01);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("gap_sample", sample, 0);
            chk("gap_run", run, 1);
        end
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            sb.push_back(d);
            send_word(d, 1'b0, i == 1, 1'b1);
        end
        cyc();
        cyc();
        chk("underrun_run_end", run, 0);

        send_word(hdr(1'b1, 1'b0, 4'd9, 16'd8), 1'b1, 1'b0, 1'b0);
        send_word(32'h9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            sb.push_back(d);
            send_word(d, 1'b0, 1'b0, 1'b1);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_run", run, 0);
        chk("clr_sample", sample, 0);
        chk("clr_ready", in_ready, 1);
        chk("clr_err_stb", err_stb, 0);
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, i == 3, 1'b0);
        tsf = vita_time + 64'd30;
        send_pkt(4'd2, 1'b1, 1'b1, tsf, 0, 3, 1'b1);
        chk("fresh_start", first_vt, tsf + 64'd1);
        cyc();
        cyc();
        chk("fresh_run_end", run, 0);

        repeat (3) cyc();
        chk("err_queue_empty", eq.size(), 0);
        chk("sample_queue_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
